// File: rtl/fifo_traffic_driver.sv
// Phased stimulus source for a FIFO: fill past full, drain past empty, simultaneous
// read/write, then LFSR-weighted random traffic. Write data is a running sequence number.
module fifo_traffic_driver #(
  parameter int          FIFO_WIDTH  = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          RAND_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          WR_THRESH   = 90,
  parameter int          RD_THRESH   = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_issued,
  output logic [15:0]           wr_acked,
  output logic [15:0]           rd_issued
);

  localparam int FILL_LEN = FIFO_DEPTH + 2;
  localparam int MAX_LEN  = (RAND_CYCLES > FILL_LEN) ? RAND_CYCLES : FILL_LEN;
  localparam int CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_LEN - 1);
  localparam logic [CNT_W-1:0] SIMUL_LAST = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] RAND_LAST  = CNT_W'(RAND_CYCLES - 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  WR_T = 8'(WR_THRESH);
  localparam logic [7:0]  RD_T = 8'(RD_THRESH);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, SIMUL, RANDOM, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [FIFO_WIDTH-1:0] seq_q, seq_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [15:0]           wr_iss_q, wr_iss_d, wr_ackc_q, wr_ackc_d, rd_iss_q, rd_iss_d;
  logic                  restart;

  // Flags are deliberately ignored: overflow and underflow are the point of the test.
  logic unused_flags;
  assign unused_flags = full ^ empty;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = FILL;
        restart = 1'b1;
      end
      FILL:    if (cnt_q == FILL_LAST)  state_d = DRAIN;
      DRAIN:   if (cnt_q == FILL_LAST)  state_d = SIMUL;
      SIMUL:   if (cnt_q == SIMUL_LAST) state_d = RANDOM;
      RANDOM:  if (cnt_q == RAND_LAST)  state_d = DONE;
      default: state_d = IDLE;
    endcase

    cnt_d = '0;
    if (state_d == state_q && state_q != IDLE && state_q != DONE) cnt_d = cnt_q + 1'b1;

    // The LFSR value feeding a RANDOM cycle is consumed first, then stepped.
    lfsr_d = lfsr_q;
    if (restart) lfsr_d = SEED;
    else if (state_q == RANDOM)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    seq_d = restart ? '0 : seq_q + FIFO_WIDTH'(wr_en_q);

    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    case (state_d)
      FILL:  wr_en_d = 1'b1;
      DRAIN: rd_en_d = 1'b1;
      SIMUL: begin
        wr_en_d = 1'b1;
        rd_en_d = 1'b1;
      end
      RANDOM: begin
        wr_en_d = ({1'b0, lfsr_d[6:0]}  < WR_T);
        rd_en_d = ({1'b0, lfsr_d[13:7]} < RD_T);
      end
      default: ;
    endcase
    busy_d = (state_d == FILL) || (state_d == DRAIN) || (state_d == SIMUL) || (state_d == RANDOM);
    done_d = (state_d == DONE);
    data_d = wr_en_d ? seq_d : '0;

    wr_iss_d  = restart ? 16'd0 : sat_inc(wr_iss_q, wr_en_q);
    rd_iss_d  = restart ? 16'd0 : sat_inc(rd_iss_q, rd_en_q);
    wr_ackc_d = restart ? 16'd0 : sat_inc(wr_ackc_q, wr_ack && busy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      seq_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      wr_iss_q  <= 16'd0;
      wr_ackc_q <= 16'd0;
      rd_iss_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      seq_q     <= seq_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
      wr_iss_q  <= wr_iss_d;
      wr_ackc_q <= wr_ackc_d;
      rd_iss_q  <= rd_iss_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_issued = wr_iss_q;
  assign wr_acked  = wr_ackc_q;
  assign rd_issued = rd_iss_q;

endmodule

// File: tb/tb_fifo_traffic_driver.sv
// Three driver lanes with different RANDOM thresholds, each feeding an 8-deep FIFO model,
// compared cycle by cycle against a phase/LFSR reference computed up front.
module tb_fifo_traffic_driver;

  localparam int D        = 8;
  localparam int R        = 20;
  localparam int NL       = 3;
  localparam int LAST     = 3 * D + 4 + R;
  localparam int DONE_CYC = LAST + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic fifo_clr = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0] wr_en_w, rd_en_w, busy_w, done_w, full_m, empty_m, wr_ack_m;
  logic [15:0]   data_w[NL], wri_w[NL], wra_w[NL], rdi_w[NL];
  int            fcnt[NL];

  int checks = 0;
  int errors = 0;
  int ack_exp[NL];
  bit ew[NL][DONE_CYC+1];
  bit er[NL][DONE_CYC+1];
  int wb[NL][DONE_CYC+1];
  int rb[NL][DONE_CYC+1];
  int wr_t[NL] = '{128, 90, 0};
  int rd_t[NL] = '{0, 60, 128};

  fifo_traffic_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .RAND_CYCLES(R), .LFSR_SEED(16'hACE1),
                        .WR_THRESH(128), .RD_THRESH(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .full(full_m[0]), .empty(empty_m[0]),
    .wr_ack(wr_ack_m[0]), .wr_en(wr_en_w[0]), .rd_en(rd_en_w[0]), .data_in(data_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .wr_issued(wri_w[0]), .wr_acked(wra_w[0]),
    .rd_issued(rdi_w[0]));

  fifo_traffic_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .RAND_CYCLES(R), .LFSR_SEED(16'hACE1),
                        .WR_THRESH(90), .RD_THRESH(60)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .full(full_m[1]), .empty(empty_m[1]),
    .wr_ack(wr_ack_m[1]), .wr_en(wr_en_w[1]), .rd_en(rd_en_w[1]), .data_in(data_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .wr_issued(wri_w[1]), .wr_acked(wra_w[1]),
    .rd_issued(rdi_w[1]));

  fifo_traffic_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .RAND_CYCLES(R), .LFSR_SEED(16'hACE1),
                        .WR_THRESH(0), .RD_THRESH(128)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .full(full_m[2]), .empty(empty_m[2]),
    .wr_ack(wr_ack_m[2]), .wr_en(wr_en_w[2]), .rd_en(rd_en_w[2]), .data_in(data_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .wr_issued(wri_w[2]), .wr_acked(wra_w[2]),
    .rd_issued(rdi_w[2]));

  // FIFO occupancy model: write accepted when not full, read when not empty, ack a cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) begin
        fcnt[l]     <= 0;
        wr_ack_m[l] <= 1'b0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (fifo_clr) begin
          fcnt[l]     <= 0;
          wr_ack_m[l] <= 1'b0;
        end else begin
          fcnt[l] <= fcnt[l] + ((wr_en_w[l] && fcnt[l] < D) ? 1 : 0)
                             - ((rd_en_w[l] && fcnt[l] > 0) ? 1 : 0);
          wr_ack_m[l] <= wr_en_w[l] && (fcnt[l] < D);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NL; gi++) begin : g_flags
    assign full_m[gi]  = (fcnt[gi] == D);
    assign empty_m[gi] = (fcnt[gi] == 0);
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected request pattern per cycle after a start, from phase lengths and the LFSR rule.
  task automatic build_model();
    logic [15:0] lf;
    int w, r;
    for (int l = 0; l < NL; l++) begin
      lf = 16'hACE1;
      w = 0;
      r = 0;
      for (int n = 1; n <= DONE_CYC; n++) begin
        wb[l][n] = w;
        rb[l][n] = r;
        if (n <= D + 2) begin
          ew[l][n] = 1'b1; er[l][n] = 1'b0;
        end else if (n <= 2 * D + 4) begin
          ew[l][n] = 1'b0; er[l][n] = 1'b1;
        end else if (n <= 3 * D + 4) begin
          ew[l][n] = 1'b1; er[l][n] = 1'b1;
        end else if (n <= LAST) begin
          ew[l][n] = (int'(lf[6:0]) < wr_t[l]);
          er[l][n] = (int'(lf[13:7]) < rd_t[l]);
          lf = lfsr_step(lf);
        end else begin
          ew[l][n] = 1'b0; er[l][n] = 1'b0;
        end
        w += int'(ew[l][n]);
        r += int'(er[l][n]);
      end
    end
  endtask

  // Starts a sequence at the next edge and compares every lane on each cycle up to DONE.
  task automatic run_seq(input string tag, input bit drain_starts, input int abort_at);
    logic [67:0] obs, exp;
    logic [15:0] dexp;
    bit stop;
    stop = 1'b0;
    for (int l = 0; l < NL; l++) ack_exp[l] = 0;
    @(negedge clk);
    start = 1'b1;
    fifo_clr = 1'b1;
    for (int n = 1; n <= DONE_CYC && !stop; n++) begin
      @(negedge clk);
      fifo_clr = 1'b0;
      for (int l = 0; l < NL; l++) begin
        dexp = ew[l][n] ? 16'(wb[l][n]) : 16'h0000;
        exp = {ew[l][n], er[l][n], (n <= LAST), (n == DONE_CYC), dexp, 16'(wb[l][n]),
               16'(ack_exp[l]), 16'(rb[l][n])};
        obs = {wr_en_w[l], rd_en_w[l], busy_w[l], done_w[l], data_w[l], wri_w[l], wra_w[l], rdi_w[l]};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s lane%0d cycle%0d {wr,rd,busy,done,data,wr_iss,wr_ack,rd_iss} got %h expected %h",
                   tag, l, n, obs, exp);
        end
        if (wr_ack_m[l] && n <= LAST) ack_exp[l]++;
      end
      if (n == D + 3) begin
        checks++;
        if (wri_w[0] !== 16'd10 || wra_w[0] !== 16'd8) begin
          errors++;
          $display("FAIL %s fill_counts wr_issued=%0d wr_acked=%0d expected 10/8", tag, wri_w[0], wra_w[0]);
        end
      end
      if (n == DONE_CYC) begin
        checks++;
        if (wri_w[0] !== 16'd38 || rdi_w[0] !== 16'd18 || wri_w[2] !== 16'd18) begin
          errors++;
          $display("FAIL %s final_counts a.wr=%0d a.rd=%0d c.wr=%0d expected 38/18/18",
                   tag, wri_w[0], rdi_w[0], wri_w[2]);
        end
      end
      if (drain_starts && n >= D + 3 && n <= 2 * D + 3) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (n == abort_at) stop = 1'b1;
    end
  endtask

  task automatic check_quiet(input string tag);
    logic [67:0] obs;
    for (int l = 0; l < NL; l++) begin
      obs = {wr_en_w[l], rd_en_w[l], busy_w[l], done_w[l], data_w[l], wri_w[l], wra_w[l], rdi_w[l]};
      checks++;
      if (obs !== 68'h0) begin
        errors++;
        $display("FAIL %s lane%0d outputs got %h expected 0", tag, l, obs);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset_hold");
    rst_n = 1'b1;
    repeat ($urandom_range(1, 5)) begin
      @(negedge clk);
      check_quiet("idle_after_reset");
    end
  endtask

  task automatic test_phases();
    run_seq("phases", 1'b0, 0);
  endtask

  task automatic test_ignored_start();
    run_seq("ignored_start", 1'b1, 0);
  endtask

  task automatic test_restart();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || wri_w[0] !== 16'd38 || wr_en_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL done_hold done=%0b busy=%0b wr_en=%0b wr_issued=%0d expected 1/0/0/38",
                 done_w[0], busy_w[0], wr_en_w[0], wri_w[0]);
      end
    end
    run_seq("restart", 1'b0, 0);
  endtask

  task automatic test_reset_mid_random();
    run_seq("pre_abort", 1'b0, 35);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    repeat (2) @(negedge clk);
    check_quiet("reset_held");
    rst_n = 1'b1;
    repeat ($urandom_range(3, 8)) begin
      @(negedge clk);
      check_quiet("idle_wait_start");
    end
    run_seq("after_abort", 1'b0, 0);
  endtask

  initial begin
    build_model();
    test_reset();
    test_phases();
    test_ignored_start();
    test_restart();
    test_reset_mid_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1, "timeout");
  end

endmodule
